y86_stat_ctrl: RTL and testbench

//   Status/commit controller for the Y86 SEQ core, downstream of fetch/decode/execute/memory.

---
 rtl/y86_stat_ctrl.sv | 125 ++++++++++++
 tb/tb_y86_stat_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/y86_stat_ctrl.sv
// Status/commit controller for the Y86 SEQ core: tracks AOK/HLT/ADR/INS, gates commit,
// and keeps saturating cycle/retire counters. Optional watchdog under `Y86_WATCHDOG_EN.
module y86_stat_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WDOG_MAX = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [3:0]       icode,
  input  logic             imem_err,
  input  logic             instruct_err,
  input  logic             mem_err,
  output logic             commit,
  output logic             run,
  output logic [2:0]       stat,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_STOP} state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [2:0]       stat_nxt;
  logic             run_nxt, halted_nxt;
  logic [CNT_W-1:0] cycle_nxt, instr_nxt;
  logic             any_err, stop_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign any_err  = imem_err | instruct_err | mem_err;
  assign stop_hit = valid & (any_err | (icode == 4'h0));
  // A faulting instruction must be blocked in the same cycle it presents its flags.
  assign commit   = (state == S_RUN) & valid & ~any_err;

`ifdef Y86_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_MAX - 1);
  logic timeout_nxt;
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    stat_nxt   = stat;
    run_nxt    = run;
    halted_nxt = halted;
    cycle_nxt  = cycle_cnt;
    instr_nxt  = instr_cnt;
`ifdef Y86_WATCHDOG_EN
    timeout_nxt = timeout;
`endif
    case (state)
      S_BOOT: begin
        state_nxt = S_RUN;
        run_nxt   = 1'b1;
      end
      S_RUN: begin
        cycle_nxt = sat_inc(cycle_cnt);
        if (stop_hit) begin
          state_nxt  = S_STOP;
          run_nxt    = 1'b0;
          halted_nxt = 1'b1;
          if (imem_err)          stat_nxt = STAT_ADR;
          else if (instruct_err) stat_nxt = STAT_INS;
          else if (mem_err)      stat_nxt = STAT_ADR;
          else begin
            // Halt is the only stopping instruction that retires.
            stat_nxt  = STAT_HLT;
            instr_nxt = sat_inc(instr_cnt);
          end
        end else begin
          if (valid) instr_nxt = sat_inc(instr_cnt);
`ifdef Y86_WATCHDOG_EN
          if (cycle_cnt == WDOG_LAST) begin
            state_nxt   = S_STOP;
            run_nxt     = 1'b0;
            halted_nxt  = 1'b1;
            stat_nxt    = STAT_HLT;
            timeout_nxt = 1'b1;
          end
`endif
        end
      end
      default: ; // S_STOP holds everything until reset
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races between blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_BOOT;
      stat      <= STAT_AOK;
      run       <= 1'b0;
      halted    <= 1'b0;
      cycle_cnt <= '0;
      instr_cnt <= '0;
`ifdef Y86_WATCHDOG_EN
      timeout   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      stat      <= stat_nxt;
      run       <= run_nxt;
      halted    <= halted_nxt;
      cycle_cnt <= cycle_nxt;
      instr_cnt <= instr_nxt;
`ifdef Y86_WATCHDOG_EN
      timeout   <= timeout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_y86_stat_ctrl.sv
// Table-driven bench for y86_stat_ctrl: each vector is driven on the falling edge, commit is checked
// combinationally, and the expected registered outputs are queued and compared after the next rising edge.
module tb_y86_stat_ctrl;

  localparam int CNT_W    = 8;
  localparam int WDOG_MAX = 16;
  localparam int SAT      = (1 << CNT_W) - 1;

  localparam logic [2:0] A = 3'd1, H = 3'd2, D = 3'd3, I = 3'd4;

  typedef struct {
    logic       rst, valid;
    logic [3:0] icode;
    logic       ie, ne, me;
    logic       c;
    logic [2:0] st;
    logic       h, r, t;
    int         cyc, ins;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1, valid = 1'b0;
  logic [3:0]       icode = 4'h1;
  logic             imem_err = 1'b0, instruct_err = 1'b0, mem_err = 1'b0;
  logic             commit, run, halted, timeout;
  logic [2:0]       stat;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  int   n_pass = 0, n_total = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  y86_stat_ctrl #(.CNT_W(CNT_W), .WDOG_MAX(WDOG_MAX)) dut (
    .clk(clk), .reset(reset), .valid(valid), .icode(icode),
    .imem_err(imem_err), .instruct_err(instruct_err), .mem_err(mem_err),
    .commit(commit), .run(run), .stat(stat), .halted(halted), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic rst, input logic v, input logic [3:0] ic,
                              input logic ie, input logic ne, input logic me, input logic c,
                              input logic [2:0] st, input logic h, input logic r, input logic t,
                              input int cyc, input int ins);
    vec_t x;
    x.rst = rst; x.valid = v; x.icode = ic; x.ie = ie; x.ne = ne; x.me = me; x.c = c;
    x.st = st; x.h = h; x.r = r; x.t = t; x.cyc = cyc; x.ins = ins;
    return x;
  endfunction

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    reset = v.rst; valid = v.valid; icode = v.icode;
    imem_err = v.ie; instruct_err = v.ne; mem_err = v.me;
    #1;
    if (!v.rst) check($sformatf("v%0d commit", idx), int'(commit), int'(v.c));
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("v%0d stat", idx),      int'(stat),      int'(e.st));
    check($sformatf("v%0d halted", idx),    int'(halted),    int'(e.h));
    check($sformatf("v%0d run", idx),       int'(run),       int'(e.r));
    check($sformatf("v%0d timeout", idx),   int'(timeout),   int'(e.t));
    check($sformatf("v%0d cycle_cnt", idx), int'(cycle_cnt), e.cyc);
    check($sformatf("v%0d instr_cnt", idx), int'(instr_cnt), e.ins);
  endtask

  // Shorthands: reset cycle, and the BOOT cycle that follows it (commit always 0 there).
  function automatic vec_t rst_v(input logic v, input logic [3:0] ic);
    return mk(1, v, ic, 0, 0, 0, 0, A, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t boot_v(input logic v);
    return mk(0, v, 4'h6, 0, 0, 0, 0, A, 0, 1, 0, 0, 0);
  endfunction

  initial begin
    // 1: five plain instructions after BOOT
    tbl.push_back(rst_v(0, 4'h6));
    tbl.push_back(boot_v(0));
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 1, A, 0, 1, 0, k, k));
    // 2: halt on the 4th instruction retires and commits, then everything freezes
    tbl.push_back(rst_v(0, 4'h6));
    tbl.push_back(boot_v(1));
    for (int k = 1; k <= 3; k++) tbl.push_back(mk(0, 1, 4'h2, 0, 0, 0, 1, A, 0, 1, 0, k, k));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, H, 1, 0, 0, 4, 4));
    tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 0, H, 1, 0, 0, 4, 4));
    tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 0, H, 1, 0, 0, 4, 4));
    // 3: instruct_err outranks mem_err, no retire
    tbl.push_back(rst_v(0, 4'h6));
    tbl.push_back(boot_v(0));
    tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 1, A, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 4'h6, 0, 1, 1, 0, I, 1, 0, 0, 2, 1));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, I, 1, 0, 0, 2, 1));
    // 4: flags without valid are ignored; imem_err outranks halt; later errors change nothing
    tbl.push_back(rst_v(0, 4'h6));
    tbl.push_back(boot_v(0));
    tbl.push_back(mk(0, 0, 4'h6, 1, 0, 0, 0, A, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'h0, 0, 1, 1, 0, A, 0, 1, 0, 2, 0));
    tbl.push_back(mk(0, 1, 4'h0, 1, 0, 0, 0, D, 1, 0, 0, 3, 0));
    tbl.push_back(mk(0, 1, 4'h6, 0, 1, 0, 0, D, 1, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 4'h6, 0, 1, 0, 0, D, 1, 0, 0, 3, 0));
    // 5: reset from STOP and mid-RUN wins over other inputs; mem_err alone gives ADR
    tbl.push_back(rst_v(1, 4'h0));
    tbl.push_back(boot_v(1));
    tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 1, A, 0, 1, 0, 1, 1));
    tbl.push_back(rst_v(1, 4'h0));
    tbl.push_back(boot_v(0));
    tbl.push_back(mk(0, 1, 4'h6, 0, 0, 1, 0, D, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'h6, 0, 0, 0, 0, D, 1, 0, 0, 1, 0));

`ifdef Y86_WATCHDOG_EN
    // 6a: watchdog fires on the 16th RUN cycle; that instruction still commits and retires
    tbl.push_back(rst_v(0, 4'h6));
    tbl.push_back(boot_v(0));
    for (int k = 1; k <= WDOG_MAX - 1; k++) tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 1, A, 0, 1, 0, k, k));
    tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 1, H, 1, 0, 1, WDOG_MAX, WDOG_MAX));
    tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 0, H, 1, 0, 1, WDOG_MAX, WDOG_MAX));
    // 6b: a real fault on that same cycle takes priority
    tbl.push_back(rst_v(0, 4'h6));
    tbl.push_back(boot_v(0));
    for (int k = 1; k <= WDOG_MAX - 1; k++) tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 1, A, 0, 1, 0, k, k));
    tbl.push_back(mk(0, 1, 4'h6, 0, 0, 1, 0, D, 1, 0, 0, WDOG_MAX, WDOG_MAX - 1));
    tbl.push_back(mk(0, 0, 4'h6, 0, 0, 0, 0, D, 1, 0, 0, WDOG_MAX, WDOG_MAX - 1));
`else
    // Saturation: both counters stick at all-ones, halt still evaluated normally
    tbl.push_back(rst_v(0, 4'h6));
    tbl.push_back(boot_v(0));
    for (int k = 1; k <= SAT + 5; k++) begin
      int s;
      s = (k > SAT) ? SAT : k;
      tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 1, A, 0, 1, 0, s, s));
    end
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, H, 1, 0, 0, SAT, SAT));
    tbl.push_back(mk(0, 1, 4'h6, 0, 0, 0, 0, H, 1, 0, 0, SAT, SAT));
`endif

    foreach (tbl[i]) apply(i, tbl[i]);
    check("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
